// File: rtl/hive_alu_result_align_pkg.sv
// Shared ALU definitions: result-source select, control word, unit latencies
// and the result-flag helper used by the writeback stage.
package hive_alu_result_align_pkg;

    localparam int ALU_W  = 32;
    localparam int THRD_W = 3;
    localparam int STK_W  = 2;
    localparam int FLG_W  = 4;
    localparam int LG_LAT = 3;
    localparam int AS_LAT = 3;
    localparam int MS_LAT = 4;

    typedef enum logic [2:0] {
        sel_none = 3'd0,
        sel_lg   = 3'd1,
        sel_as   = 3'd2,
        sel_ms   = 3'd3,
        sel_lit  = 3'd4
    } ALU_SEL_T;

    typedef struct packed {
        logic [THRD_W-1:0] thrd;
        ALU_SEL_T          sel;
        logic [STK_W-1:0]  dst;
    } ctl_dat_t;

    // Encodings 5..7 are not sources and therefore never write back.
    function automatic logic sel_writes(input ALU_SEL_T s);
        return s inside {sel_lg, sel_as, sel_ms, sel_lit};
    endfunction

    // {neg, zero, odd, unit flag bit 0}
    function automatic logic [FLG_W-1:0] calc_flg(input logic [ALU_W-1:0] res,
                                                  input logic unit_b0);
        return {res[ALU_W-1], (res == '0), res[0], unit_b0};
    endfunction

endpackage

// File: rtl/hive_ctl_pipe.sv
// N-stage {vld, thrd, sel, dst} delay line with per-thread kill. Stage 0 is the
// issue input; live_o[k] is stage k's valid with this cycle's kill applied.
module hive_ctl_pipe
    import hive_alu_result_align_pkg::*;
#(
    parameter int N = MS_LAT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 vld_i,
    input  ctl_dat_t             dat_i,
    input  logic                 kill_vld_i,
    input  logic [THRD_W-1:0]    kill_thrd_i,
    output logic [N:0]           live_o,
    output ctl_dat_t [N:0]       dat_o
);

    logic [N:1]     vld_q;
    ctl_dat_t [N:1] dat_q;
    logic [N:0]     vld_raw;

    assign vld_raw = {vld_q, vld_i};
    assign dat_o   = {dat_q, dat_i};

    always_comb begin
        live_o = '0;
        for (int k = 0; k <= N; k++) begin
            live_o[k] = vld_raw[k] & ~(kill_vld_i && (dat_o[k].thrd == kill_thrd_i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= live_o[N-1:0];
        end
    end

    // Payload is only meaningful alongside a set valid, so it carries no reset.
    always_ff @(posedge clk_i) begin
        dat_q <= dat_o[N-1:0];
    end

endmodule

// File: rtl/hive_alu_result_align.sv
// ALU writeback aligner: delays issued control to the slowest unit's latency,
// holds each unit result from its arrival stage and emits one registered word.
module hive_alu_result_align
    import hive_alu_result_align_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vld_i,
    input  logic [THRD_W-1:0] thrd_i,
    input  ALU_SEL_T          sel_i,
    input  logic [STK_W-1:0]  dst_i,
    input  logic [ALU_W-1:0]  lit_i,
    input  logic              kill_vld_i,
    input  logic [THRD_W-1:0] kill_thrd_i,
    input  logic [ALU_W-1:0]  lg_res_i,
    input  logic [FLG_W-1:0]  lg_flg_i,
    input  logic [ALU_W-1:0]  as_res_i,
    input  logic [ALU_W-1:0]  ms_res_i,
    output logic              wr_o,
    output logic [THRD_W-1:0] thrd_o,
    output logic [STK_W-1:0]  dst_o,
    output logic [ALU_W-1:0]  result_o,
    output logic [FLG_W-1:0]  flg_o
);

    localparam int LG_D = MS_LAT - LG_LAT;
    localparam int AS_D = MS_LAT - AS_LAT;

    ctl_dat_t              dat_in;
    logic [MS_LAT:0]       live;
    ctl_dat_t [MS_LAT:0]   dat;
    logic                  lg_cap;
    logic                  as_cap;
    logic [ALU_W-1:0]      lg_ms;
    logic                  lg_ub_ms;
    logic [ALU_W-1:0]      as_ms;
    logic [MS_LAT:1][ALU_W-1:0] lit_q;
    logic                  unused_ctl;
    logic                  unused_flg;

    assign dat_in = '{thrd: thrd_i, sel: sel_i, dst: dst_i};

    hive_ctl_pipe #(.N(MS_LAT)) u_ctl_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .vld_i       (vld_i),
        .dat_i       (dat_in),
        .kill_vld_i  (kill_vld_i),
        .kill_thrd_i (kill_thrd_i),
        .live_o      (live),
        .dat_o       (dat)
    );

    assign unused_ctl = ^{dat, live};
    assign unused_flg = ^lg_flg_i[FLG_W-1:1];

    assign lg_cap = live[LG_LAT] && (dat[LG_LAT].sel == sel_lg);
    assign as_cap = live[AS_LAT] && (dat[AS_LAT].sel == sel_as);

    // Hold registers load only at their unit's arrival stage, then ride along.
    if (LG_D == 0) begin : g_lg_direct
        assign lg_ms    = lg_res_i;
        assign lg_ub_ms = lg_flg_i[0];
    end else begin : g_lg_hold
        logic [LG_D-1:0][ALU_W-1:0] res_q;
        logic [LG_D-1:0]            ub_q;
        always_ff @(posedge clk_i) begin
            if (lg_cap) begin
                res_q[0] <= lg_res_i;
                ub_q[0]  <= lg_flg_i[0];
            end
            for (int i = 1; i < LG_D; i++) begin
                res_q[i] <= res_q[i-1];
                ub_q[i]  <= ub_q[i-1];
            end
        end
        assign lg_ms    = res_q[LG_D-1];
        assign lg_ub_ms = ub_q[LG_D-1];
    end

    if (AS_D == 0) begin : g_as_direct
        assign as_ms = as_res_i;
    end else begin : g_as_hold
        logic [AS_D-1:0][ALU_W-1:0] res_q;
        always_ff @(posedge clk_i) begin
            if (as_cap) begin
                res_q[0] <= as_res_i;
            end
            for (int i = 1; i < AS_D; i++) begin
                res_q[i] <= res_q[i-1];
            end
        end
        assign as_ms = res_q[AS_D-1];
    end

    always_ff @(posedge clk_i) begin
        if (vld_i && (sel_i == sel_lit)) begin
            lit_q[1] <= lit_i;
        end
        for (int k = 2; k <= MS_LAT; k++) begin
            lit_q[k] <= lit_q[k-1];
        end
    end

    // Stage MS_LAT: pick the source and form the registered writeback.
    logic              wr_d;
    logic [ALU_W-1:0]  res_d;
    logic              ub_d;
    logic [FLG_W-1:0]  flg_d;
    logic              wr_q;
    logic [THRD_W-1:0] thrd_q;
    logic [STK_W-1:0]  dst_q;
    logic [ALU_W-1:0]  res_q;
    logic [FLG_W-1:0]  flg_q;

    always_comb begin
        res_d = '0;
        ub_d  = 1'b0;
        case (dat[MS_LAT].sel)
            sel_lg: begin
                res_d = lg_ms;
                ub_d  = lg_ub_ms;
            end
            sel_as:  res_d = as_ms;
            sel_ms:  res_d = ms_res_i;
            sel_lit: res_d = lit_q[MS_LAT];
            default: res_d = '0;
        endcase
        wr_d  = live[MS_LAT] && sel_writes(dat[MS_LAT].sel);
        flg_d = calc_flg(res_d, ub_d);
    end

    // Data outputs hold their last writeback while no write is in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= 1'b0;
            thrd_q <= '0;
            dst_q  <= '0;
            res_q  <= '0;
            flg_q  <= '0;
        end else begin
            wr_q <= wr_d;
            if (wr_d) begin
                thrd_q <= dat[MS_LAT].thrd;
                dst_q  <= dat[MS_LAT].dst;
                res_q  <= res_d;
                flg_q  <= flg_d;
            end
        end
    end

    assign wr_o     = wr_q;
    assign thrd_o   = thrd_q;
    assign dst_o    = dst_q;
    assign result_o = res_q;
    assign flg_o    = flg_q;

endmodule

// File: tb/tb_hive_alu_result_align.sv
// Bench for hive_alu_result_align: table vectors, hand-built corner sequences
// and a random stream, all checked against a per-op scoreboard model.
module tb_hive_alu_result_align;
    import hive_alu_result_align_pkg::*;

    typedef struct {
        logic        vld;
        logic [2:0]  sel;
        logic [2:0]  thrd;
        logic [1:0]  dst;
        logic [31:0] lit;
        logic [31:0] lgv;
        logic [31:0] asv;
        logic [31:0] msv;
        logic [3:0]  lgf;
        logic        kill;
        logic [2:0]  kthrd;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] exp_res;
        logic [3:0]  exp_flg;
    } tv_t;

    localparam int MAXC = 2048;

    logic              clk;
    logic              rst_i;
    logic              vld_i;
    logic [THRD_W-1:0] thrd_i;
    ALU_SEL_T          sel_i;
    logic [STK_W-1:0]  dst_i;
    logic [ALU_W-1:0]  lit_i;
    logic              kill_vld_i;
    logic [THRD_W-1:0] kill_thrd_i;
    logic [ALU_W-1:0]  lg_res_i;
    logic [FLG_W-1:0]  lg_flg_i;
    logic [ALU_W-1:0]  as_res_i;
    logic [ALU_W-1:0]  ms_res_i;
    logic              wr_o;
    logic [THRD_W-1:0] thrd_o;
    logic [STK_W-1:0]  dst_o;
    logic [ALU_W-1:0]  result_o;
    logic [FLG_W-1:0]  flg_o;

    op_t hist [MAXC];
    int  cyc;
    int  rst_last;
    int  n_chk;
    int  n_pass;
    bit  written;

    hive_alu_result_align dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .vld_i       (vld_i),
        .thrd_i      (thrd_i),
        .sel_i       (sel_i),
        .dst_i       (dst_i),
        .lit_i       (lit_i),
        .kill_vld_i  (kill_vld_i),
        .kill_thrd_i (kill_thrd_i),
        .lg_res_i    (lg_res_i),
        .lg_flg_i    (lg_flg_i),
        .as_res_i    (as_res_i),
        .ms_res_i    (ms_res_i),
        .wr_o        (wr_o),
        .thrd_o      (thrd_o),
        .dst_o       (dst_o),
        .result_o    (result_o),
        .flg_o       (flg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    endtask

    function automatic op_t mk(input logic v, input logic [2:0] sel, input logic [2:0] thrd,
                               input logic [1:0] dst, input logic [31:0] lit,
                               input logic [31:0] lgv, input logic [31:0] asv,
                               input logic [31:0] msv, input logic [3:0] lgf,
                               input logic kill, input logic [2:0] kthrd);
        op_t o;
        o.vld = v;  o.sel = sel;  o.thrd = thrd;  o.dst = dst;  o.lit = lit;
        o.lgv = lgv; o.asv = asv; o.msv = msv; o.lgf = lgf;
        o.kill = kill; o.kthrd = kthrd;
        return o;
    endfunction

    function automatic tv_t mktv(input op_t o, input logic [31:0] r, input logic [3:0] f);
        tv_t t;
        t.op = o; t.exp_res = r; t.exp_flg = f;
        return t;
    endfunction

    function automatic op_t idle();
        return mk(1'b0, 3'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 3'd0);
    endfunction

    function automatic op_t rnd_op();
        return mk($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 6) == 0, 3'($urandom_range(0, 7)));
    endfunction

    // Reference: an issued op writes back MS_LAT+1 cycles later unless it has no
    // source, a reset intervened, or its thread was killed while in flight.
    task automatic model_check(input int c);
        int          t;
        logic        ew;
        op_t         o;
        logic [31:0] r;
        logic [3:0]  f;
        t  = c - (MS_LAT + 1);
        ew = 1'b0;
        r  = '0;
        o  = idle();
        if (t >= 0 && t > rst_last) begin
            o  = hist[t];
            ew = o.vld && (o.sel >= 3'd1) && (o.sel <= 3'd4);
            for (int k = t; k <= t + MS_LAT; k++) begin
                if (hist[k].kill && hist[k].kthrd == o.thrd) ew = 1'b0;
            end
        end
        chk("wr_o", wr_o, ew);
        if (ew) begin
            case (o.sel)
                3'd1:    r = o.lgv;
                3'd2:    r = o.asv;
                3'd3:    r = o.msv;
                default: r = o.lit;
            endcase
            f = {r[31], r == 32'd0, r[0], (o.sel == 3'd1) ? o.lgf[0] : 1'b0};
            chk("thrd_o", thrd_o, o.thrd);
            chk("dst_o", dst_o, o.dst);
            chk("result_o", result_o, r);
            chk("flg_o", flg_o, f);
            written = 1'b1;
        end else if (!written) begin
            chk("idle_outputs_zero", {thrd_o, dst_o, result_o, flg_o}, 64'd0);
        end
    endtask

    // One clock: present the op, play the units back from history, check at negedge.
    task automatic tick(input op_t o);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d, want < %0d", cyc, MAXC);
            $fatal(1);
        end
        hist[cyc]   = o;
        vld_i       = o.vld;
        thrd_i      = o.thrd;
        sel_i       = ALU_SEL_T'(o.sel);
        dst_i       = o.dst;
        lit_i       = o.lit;
        kill_vld_i  = o.kill;
        kill_thrd_i = o.kthrd;
        lg_res_i    = $urandom;
        lg_flg_i    = 4'($urandom_range(0, 15));
        as_res_i    = $urandom;
        ms_res_i    = $urandom;
        if (cyc >= LG_LAT && hist[cyc-LG_LAT].sel == 3'd1) begin
            lg_res_i = hist[cyc-LG_LAT].lgv;
            lg_flg_i = hist[cyc-LG_LAT].lgf;
        end
        if (cyc >= AS_LAT && hist[cyc-AS_LAT].sel == 3'd2) as_res_i = hist[cyc-AS_LAT].asv;
        if (cyc >= MS_LAT && hist[cyc-MS_LAT].sel == 3'd3) ms_res_i = hist[cyc-MS_LAT].msv;
        @(negedge clk);
        model_check(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_async_wr", wr_o, 1'b0);
        chk("rst_async_data", {thrd_o, dst_o, result_o, flg_o}, 64'd0);
        rst_last = cyc;
        written  = 1'b0;
        tick(idle());
        rst_i = 1'b0;
    endtask

    initial begin
        tv_t tv [11];

        n_chk = 0; n_pass = 0; cyc = 0; rst_last = -1; written = 1'b0;
        for (int i = 0; i < MAXC; i++) hist[i] = idle();
        rst_i = 1'b1; vld_i = 1'b0; thrd_i = '0; sel_i = sel_none; dst_i = '0; lit_i = '0;
        kill_vld_i = 1'b0; kill_thrd_i = '0;
        lg_res_i = '0; lg_flg_i = '0; as_res_i = '0; ms_res_i = '0;

        tv[0]  = mktv(mk(1, 3'd1, 3'd2, 2'd1, 0, 32'h0000_00FF, 0, 0, 4'h0, 0, 0), 32'h0000_00FF, 4'b0010);
        tv[1]  = mktv(mk(1, 3'd1, 3'd0, 2'd3, 0, 32'h0, 0, 0, 4'h1, 0, 0), 32'h0, 4'b0101);
        tv[2]  = mktv(mk(1, 3'd2, 3'd1, 2'd0, 0, 0, 32'h0, 0, 4'hF, 0, 0), 32'h0, 4'b0100);
        tv[3]  = mktv(mk(1, 3'd2, 3'd1, 2'd2, 0, 0, 32'h8000_0000, 0, 4'h0, 0, 0), 32'h8000_0000, 4'b1000);
        tv[4]  = mktv(mk(1, 3'd3, 3'd5, 2'd1, 0, 0, 0, 32'hFFFF_FFFF, 4'h0, 0, 0), 32'hFFFF_FFFF, 4'b1010);
        tv[5]  = mktv(mk(1, 3'd4, 3'd6, 2'd2, 32'd4, 0, 0, 0, 4'h0, 0, 0), 32'd4, 4'b0000);
        tv[6]  = mktv(mk(1, 3'd4, 3'd7, 2'd3, 32'h8000_0001, 0, 0, 0, 4'h0, 0, 0), 32'h8000_0001, 4'b1010);
        tv[7]  = mktv(mk(1, 3'd1, 3'd3, 2'd0, 0, 32'd3, 0, 0, 4'hE, 0, 0), 32'd3, 4'b0010);
        tv[8]  = mktv(mk(1, 3'd3, 3'd4, 2'd1, 0, 0, 0, 32'h0, 4'h0, 0, 0), 32'h0, 4'b0100);
        tv[9]  = mktv(mk(1, 3'd2, 3'd7, 2'd2, 0, 0, 32'd7, 0, 4'hF, 0, 0), 32'd7, 4'b0010);
        tv[10] = mktv(mk(1, 3'd1, 3'd2, 2'd3, 0, 32'hFFFF_FFFE, 0, 0, 4'h1, 0, 0), 32'hFFFF_FFFE, 4'b1001);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr", wr_o, 1'b0);
        chk("reset_thrd", thrd_o, 3'd0);
        chk("reset_dst", dst_o, 2'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_flg", flg_o, 4'd0);
        rst_i = 1'b0;

        // Isolated ops from the table, each checked at issue + MS_LAT + 1.
        for (int i = 0; i < 11; i++) begin
            tick(tv[i].op);
            repeat (MS_LAT) tick(idle());
            chk("tv_wr", wr_o, 1'b1);
            chk("tv_thrd", thrd_o, tv[i].op.thrd);
            chk("tv_dst", dst_o, tv[i].op.dst);
            chk("tv_result", result_o, tv[i].exp_res);
            chk("tv_flg", flg_o, tv[i].exp_flg);
        end

        // Back-to-back ops of every source.
        tick(mk(1, 3'd1, 3'd0, 2'd0, 0, 32'd1, 0, 0, 4'h1, 0, 0));
        tick(mk(1, 3'd2, 3'd1, 2'd1, 0, 0, 32'd2, 0, 4'h0, 0, 0));
        tick(mk(1, 3'd3, 3'd2, 2'd2, 0, 0, 0, 32'd3, 4'h0, 0, 0));
        tick(mk(1, 3'd4, 3'd3, 2'd3, 32'd4, 0, 0, 0, 4'h0, 0, 0));
        repeat (6) tick(idle());

        // Alternating threads 3/4 with a thread-3 kill once the pipe is full.
        for (int i = 0; i < 6; i++) begin
            tick(mk(1, 3'd4, (i % 2 == 0) ? 3'd3 : 3'd4, 2'(i), 32'(100 + i), 0, 0, 0, 4'h0,
                    i == 4, 3'd3));
        end
        tick(mk(1, 3'd4, 3'd3, 2'd2, 32'd200, 0, 0, 0, 4'h0, 0, 0));
        repeat (6) tick(idle());

        // No-source, killed-at-issue, invalid sel, then reset mid-stream.
        tick(mk(1, 3'd0, 3'd1, 2'd1, 32'd9, 0, 0, 0, 4'h0, 0, 0));
        tick(mk(1, 3'd4, 3'd5, 2'd1, 32'd10, 0, 0, 0, 4'h0, 1, 3'd5));
        tick(mk(1, 3'd6, 3'd2, 2'd0, 32'd11, 0, 0, 0, 4'h0, 0, 0));
        tick(mk(1, 3'd4, 3'd1, 2'd2, 32'd12, 0, 0, 0, 4'h0, 1, 3'd6));
        tick(mk(1, 3'd1, 3'd2, 2'd3, 0, 32'h55, 0, 0, 4'h1, 0, 0));
        tick(mk(1, 3'd2, 3'd3, 2'd0, 0, 0, 32'h66, 0, 4'h0, 0, 0));
        tick(mk(1, 3'd3, 3'd4, 2'd1, 0, 0, 0, 32'h77, 4'h0, 0, 0));
        do_reset();
        repeat (7) tick(idle());
        tick(mk(1, 3'd4, 3'd6, 2'd1, 32'hABCD, 0, 0, 0, 4'h0, 0, 0));
        repeat (6) tick(idle());

        // Random stream with one reset partway through.
        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset();
            tick(rnd_op());
        end
        repeat (6) tick(idle());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
